// File: rtl/memory_cycle_pkg.sv
// rtl/memory_cycle_pkg.sv - shared encodings for the MEM pipeline stage
package memory_cycle_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    localparam logic RESULT_SRC_MEM  = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 16;

    function automatic logic is_misaligned(input logic access, input logic [1:0] addr_lsb);
        return access && (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// rtl/memory_cycle_if.sv - data memory req/ready bus
interface memory_cycle_if #(
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/memory_cycle_dmem_handshake.sv
// rtl/memory_cycle_dmem_handshake.sv - request FSM and wait-cycle timeout counter
module dmem_handshake
    import memory_cycle_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic StallM,
    output logic complete,
    output logic abort
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dmem_req = req_valid;
        StallM   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(1);
                        StallM  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // ready is honoured ahead of the timeout on the final wait cycle
                if (req_valid && dmem_ready) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    StallM = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage: data memory access and MEM/WB register
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              ResultSrcM,
    input  logic [4:0]        RD_M,
    input  logic [DATA_W-1:0] PCPlus4M,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [DATA_W-1:0] ALU_ResultM,
    memory_cycle_if.master    dmem,
    output logic              StallM,
    output logic              BusErr,
    output logic              RegWriteW,
    output logic              ResultSrcW,
    output logic [4:0]        RD_W,
    output logic [DATA_W-1:0] PCPlus4W,
    output logic [DATA_W-1:0] ALU_ResultW,
    output logic [DATA_W-1:0] ReadDataW
);

    logic access, misalign, is_load, complete, abort;

    assign is_load  = (ResultSrcM == RESULT_SRC_MEM);
    assign access   = MemWriteM | is_load;
    assign misalign = is_misaligned(access, ALU_ResultM[1:0]);

    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = ALU_ResultM;
    assign dmem.dmem_wdata = WriteDataM;

    dmem_handshake #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_handshake (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (access & ~misalign),
        .dmem_ready (dmem.dmem_ready),
        .dmem_req   (dmem.dmem_req),
        .StallM     (StallM),
        .complete   (complete),
        .abort      (abort)
    );

    logic              regwrite_q, regwrite_d;
    logic              resultsrc_q, resultsrc_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] pcplus4_q, pcplus4_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              buserr_q, buserr_d;

    always_comb begin
        regwrite_d  = RegWriteM;
        resultsrc_d = ResultSrcM;
        rd_d        = RD_M;
        pcplus4_d   = PCPlus4M;
        alu_d       = ALU_ResultM;
        rdata_d     = '0;
        buserr_d    = buserr_q;
        if (StallM) begin
            // bubble while the access is outstanding; the instruction enters W once, on completion
            regwrite_d  = 1'b0;
            resultsrc_d = 1'b0;
            rd_d        = '0;
            pcplus4_d   = '0;
            alu_d       = '0;
        end else if (abort || misalign) begin
            regwrite_d = 1'b0;
            buserr_d   = 1'b1;
        end else if (complete && !MemWriteM) begin
            rdata_d = dmem.dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= '0;
            pcplus4_q   <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            buserr_q    <= 1'b0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pcplus4_q   <= pcplus4_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            buserr_q    <= buserr_d;
        end
    end

    assign BusErr      = buserr_q;
    assign RegWriteW   = regwrite_q;
    assign ResultSrcW  = resultsrc_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pcplus4_q;
    assign ALU_ResultW = alu_q;
    assign ReadDataW   = rdata_q;

endmodule
